// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared load/store codes, pipeline bus widths and field offsets.
package mem_stage_pkg;
  typedef enum logic [3:0] {
    LD_W  = 4'b0000,
    LD_B  = 4'b0001,
    LD_BU = 4'b0010,
    LD_H  = 4'b0011,
    LD_HU = 4'b0100
  } ld_st_t;
  localparam int EX_MEM_W = 139;
  localparam int MEM_WB_W = 70;
  localparam int MEM_ID_W = 39;
  localparam int EXB_PC = 107, EXB_RES_MEM = 106, EXB_RF_WE = 105, EXB_WADDR = 100;
  localparam int EXB_ALU = 68, EXB_RKD = 36, EXB_ADDR = 4, EXB_TYPE = 0;
  localparam int WBB_PC = 38, WBB_RF_WE = 37, WBB_WADDR = 32, WBB_RESULT = 0;
  localparam int IDB_RES_MEM = 38, IDB_RF_WE = 37, IDB_WADDR = 32, IDB_FWD = 0;
  typedef struct packed {
    logic [31:0] pc;
    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;
    logic [31:0] rkd_value;
    logic [31:0] sram_addr;
    logic [3:0]  ld_st_type;
  } ex_mem_bus_t;
endpackage

// File: rtl/load_align.sv
// load_align: picks and extends the addressed byte/half/word from SRAM read data.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [3:0]  ld_st_type_i,
  output logic [31:0] result_o
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  always_comb begin
    byte_v   = rdata_i[{addr_i, 3'b000} +: 8];
    half_v   = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    result_o = ld_st_type_i == LD_B  ? {{24{byte_v[7]}}, byte_v} :
               ld_st_type_i == LD_BU ? {24'b0, byte_v} :
               ld_st_type_i == LD_H  ? {{16{half_v[15]}}, half_v} :
               ld_st_type_i == LD_HU ? {16'b0, half_v} : rdata_i;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage; macro MEM_LOAD_FWD_EN forwards load data (not alu_result) to ID.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                ex_to_mem_valid,
  input  logic [EX_MEM_W-1:0] ex_to_mem_bus,
  output logic                mem_allowin,
  input  logic [31:0]         data_sram_rdata,
  input  logic                wb_allowin,
  output logic                mem_to_wb_valid,
  output logic [MEM_WB_W-1:0] mem_to_wb_bus,
  output logic [MEM_ID_W-1:0] mem_to_id_bus
);
  ex_mem_bus_t ex_q, ex_d;
  logic        valid_q, valid_d, fresh_q, fresh_d, take;
  logic [31:0] hold_q, hold_d, load_src, load_data, final_result, fwd_result;
  logic        unused_ok;
  assign mem_allowin     = ~valid_q | wb_allowin;
  assign mem_to_wb_valid = valid_q;
  assign take            = ex_to_mem_valid & mem_allowin;
  always_comb begin
    valid_d = mem_allowin ? ex_to_mem_valid : valid_q;
    ex_d    = take ? ex_mem_bus_t'(ex_to_mem_bus) : ex_q;
    fresh_d = take;
    hold_d  = fresh_q ? data_sram_rdata : hold_q;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      fresh_q <= 1'b0;
      hold_q  <= '0;
      ex_q    <= '0;
    end else begin
      valid_q <= valid_d;
      fresh_q <= fresh_d;
      hold_q  <= hold_d;
      ex_q    <= ex_d;
    end
  end
  // Raw SRAM data is only valid in the first occupancy cycle; stalls replay the held copy.
  assign load_src = fresh_q ? data_sram_rdata : hold_q;
  load_align u_load_align (
    .rdata_i      (load_src),
    .addr_i       (ex_q.sram_addr[1:0]),
    .ld_st_type_i (ex_q.ld_st_type),
    .result_o     (load_data)
  );
  assign final_result = ex_q.res_from_mem ? load_data : ex_q.alu_result;
`ifdef MEM_LOAD_FWD_EN
  assign fwd_result = final_result;
`else
  assign fwd_result = ex_q.alu_result;
`endif
  assign mem_to_wb_bus = {ex_q.pc, ex_q.rf_we, ex_q.rf_waddr, final_result};
  assign mem_to_id_bus = {ex_q.res_from_mem & valid_q, ex_q.rf_we & valid_q, ex_q.rf_waddr, fwd_result};
  assign unused_ok     = ^{ex_q.rkd_value, ex_q.sram_addr[31:2]};
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against an instruction-level model.
module tb_mem_stage;
  import mem_stage_pkg::*;
  logic                clk = 1'b0, resetn = 1'b0, ex_to_mem_valid = 1'b0, wb_allowin = 1'b0;
  logic [EX_MEM_W-1:0] ex_to_mem_bus = '0;
  logic [31:0]         data_sram_rdata = '0;
  logic                mem_allowin, mem_to_wb_valid;
  logic [MEM_WB_W-1:0] mem_to_wb_bus;
  logic [MEM_ID_W-1:0] mem_to_id_bus;
  int checks = 0, failures = 0;
  typedef struct {
    logic [31:0] pc;
    logic        res;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] alu, rkd, addr;
    logic [3:0]  t;
    logic [31:0] word;
  } ins_t;
  ins_t m_cur, nop_i, ins;
  logic m_valid = 1'b0, m_fresh = 1'b0, m_zero = 1'b1;
  mem_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .ex_to_mem_valid (ex_to_mem_valid),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .mem_allowin     (mem_allowin),
    .data_sram_rdata (data_sram_rdata),
    .wb_allowin      (wb_allowin),
    .mem_to_wb_valid (mem_to_wb_valid),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_to_id_bus   (mem_to_id_bus)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] load_val(ins_t i);
    logic [31:0] b, h;
    b = (i.word >> (8 * i.addr[1:0])) & 32'hFF;
    h = (i.word >> (16 * i.addr[1])) & 32'hFFFF;
    case (i.t)
      4'd1:    return b >= 128 ? b - 32'd256 : b;
      4'd2:    return b;
      4'd3:    return h >= 32768 ? h - 32'd65536 : h;
      4'd4:    return h;
      default: return i.word;
    endcase
  endfunction
  function automatic logic [31:0] exp_final(ins_t i);
    return i.res ? load_val(i) : i.alu;
  endfunction
  function automatic logic [31:0] fwd_sel(logic [31:0] ld, logic [31:0] alu);
`ifdef MEM_LOAD_FWD_EN
    return ld;
`else
    return alu;
`endif
  endfunction
  function automatic ins_t mk(logic [3:0] t, logic [31:0] addr, logic [31:0] word);
    ins_t i;
    i.pc   = $urandom;
    i.res  = ~t[3];
    i.we   = 1'b1;
    i.wa   = 5'($urandom_range(1, 31));
    i.alu  = i.res ? addr : $urandom;
    i.rkd  = $urandom;
    i.addr = addr;
    i.t    = t;
    i.word = word;
    return i;
  endfunction
  function automatic ins_t rnd_ins();
    ins_t i;
    int k;
    logic [3:0] t;
    logic [31:0] a;
    k = $urandom_range(0, 5);
    t = k < 5 ? 4'(k) : {1'b1, 3'($urandom)};
    a = $urandom;
    if (t == 4'd0) a[1:0] = 2'b00;
    if (t == 4'd3 || t == 4'd4) a[0] = 1'b0;
    i = mk(t, a, $urandom);
    i.we = 1'($urandom);
    return i;
  endfunction
  function automatic logic [EX_MEM_W-1:0] pack(ins_t i);
    return {i.pc, i.res, i.we, i.wa, i.alu, i.rkd, i.addr, i.t};
  endfunction
  task automatic chk(string tag, logic [69:0] got, logic [69:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(logic rn, logic ev, ins_t in, logic wba, logic [31:0] junk);
    logic [69:0] e_wb;
    logic [38:0] e_id;
    logic [31:0] f;
    resetn          = rn;
    ex_to_mem_valid = ev;
    ex_to_mem_bus   = pack(in);
    wb_allowin      = wba;
    data_sram_rdata = m_fresh ? m_cur.word : junk;
    #1;
    chk("allowin", 70'(mem_allowin), 70'(!m_valid || wba));
    chk("wb_valid", 70'(mem_to_wb_valid), 70'(m_valid));
    if (m_valid || m_zero) begin
      f    = exp_final(m_cur);
      e_wb = m_valid ? {m_cur.pc, m_cur.we, m_cur.wa, f} : '0;
      e_id = m_valid ? {m_cur.res, m_cur.we, m_cur.wa, fwd_sel(f, m_cur.alu)} : '0;
      chk("wb_bus", mem_to_wb_bus, e_wb);
      chk("id_bus", 70'(mem_to_id_bus), 70'(e_id));
    end
    @(posedge clk);
    if (!rn) begin
      m_valid = 1'b0;
      m_fresh = 1'b0;
      m_zero  = 1'b1;
    end else begin
      m_fresh = ev && (!m_valid || wba);
      if (m_fresh) begin
        m_cur  = in;
        m_zero = 1'b0;
      end
      if (!m_valid || wba) m_valid = ev;
    end
    @(negedge clk);
  endtask
  task automatic peek(string tag, logic [31:0] wb_exp, logic [31:0] id_exp);
    data_sram_rdata = m_fresh ? m_cur.word : 32'h1111_1111;
    #1;
    chk(tag, 70'(mem_to_wb_bus[31:0]), 70'(wb_exp));
    chk({tag, "_fwd"}, 70'(mem_to_id_bus[31:0]), 70'(id_exp));
  endtask
  initial begin
    nop_i = mk(4'b1000, 32'h0, 32'h0);
    m_cur = nop_i;
    m_cur.pc = '0; m_cur.we = 1'b0; m_cur.wa = '0; m_cur.alu = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    step(1, 0, nop_i, 1, $urandom);
    ins = mk(LD_B, 32'h1000_0003, 32'h80FF_1234);
    step(1, 1, ins, 1, $urandom);
    peek("ld_b", 32'hFFFF_FF80, fwd_sel(32'hFFFF_FF80, 32'h1000_0003));
    ins = mk(LD_BU, 32'h1000_0003, 32'h80FF_1234);
    step(1, 1, ins, 1, $urandom);
    peek("ld_bu", 32'h0000_0080, fwd_sel(32'h0000_0080, 32'h1000_0003));
    ins = mk(LD_H, 32'h2000_0002, 32'h8001_7FFF);
    step(1, 1, ins, 1, $urandom);
    peek("ld_h", 32'hFFFF_8001, fwd_sel(32'hFFFF_8001, 32'h2000_0002));
    ins = mk(LD_HU, 32'h2000_0002, 32'h8001_7FFF);
    step(1, 1, ins, 1, $urandom);
    peek("ld_hu", 32'h0000_8001, fwd_sel(32'h0000_8001, 32'h2000_0002));
    ins = mk(LD_W, 32'h3000_0000, 32'hDEAD_BEEF);
    step(1, 1, ins, 1, $urandom);
    peek("ld_w", 32'hDEAD_BEEF, fwd_sel(32'hDEAD_BEEF, 32'h3000_0000));
    repeat (3) begin
      step(1, 1, rnd_ins(), 0, 32'h1111_1111);
      peek("ld_w_stall", 32'hDEAD_BEEF, fwd_sel(32'hDEAD_BEEF, 32'h3000_0000));
    end
    step(1, 0, nop_i, 1, 32'h1111_1111);
    step(1, 0, nop_i, 1, $urandom);
    ins = mk(4'b1000, 32'h0, 32'h0);
    ins.alu = 32'h0000_0042;
    ins.wa  = 5'd5;
    repeat (6) begin
      ins.pc = $urandom;
      step(1, 1, ins, 1, $urandom);
    end
    step(1, 0, nop_i, 1, $urandom);
    step(1, 1, mk(LD_W, 32'h4000_0000, 32'hCAFE_F00D), 1, $urandom);
    step(1, 0, nop_i, 0, $urandom);
    step(0, 1, rnd_ins(), 0, $urandom);
    step(1, 0, nop_i, 0, $urandom);
    repeat (400) begin
      step(($urandom % 64) != 0, ($urandom % 4) != 0, rnd_ins(), ($urandom % 4) != 0, $urandom);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
